// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage MIPS core front end.
//   INSTR_W           instruction width
//   NOP_INSTR         word injected into pipeline registers as a bubble
//   RESET_PC_DEFAULT  PC loaded on reset
//   fetch_state_t     fetch FSM states (RUN / MISS / HELD)
//   align_word()      forces the two byte-offset bits of an address to 00
package core_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0]        RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        HELD = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold and flush.
//   clk, rst    clock, synchronous active-high reset (loads NOP, pc4 = 0, invalid)
//   flush       load a bubble (NOP, pc4 = 0, valid = 0); wins over en
//   en          load d_* ; when both flush and en are low the register holds
//   d_instr/d_pc4/d_valid   next contents
//   q_instr/q_pc4/q_valid   current contents
module if_id_reg
    import core_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               en,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [31:0]        d_pc4,
    input  logic               d_valid,
    output logic [INSTR_W-1:0] q_instr,
    output logic [31:0]        q_pc4,
    output logic               q_valid
);

    logic [INSTR_W-1:0] instr_d, instr_q;
    logic [31:0]        pc4_d, pc4_q;
    logic               valid_d, valid_q;

    // Next-contents selection: flush beats load, otherwise hold.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP;
            pc4_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (en) begin
            instr_d = d_instr;
            pc4_d   = d_pc4;
            valid_d = d_valid;
        end else begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end
    end

    // Register update with synchronous reset to a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign q_instr = instr_q;
    assign q_pc4   = pc4_q;
    assign q_valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, I-cache request handshake and IF/ID.
//   clk, rst                 clock, synchronous active-high reset
//   PCWrite, if_id_Write     hazard-unit controls (0 = freeze PC / hold IF/ID)
//   global_stall             D-cache stall, freezes every flop of this block
//   redirect_valid/_pc       taken branch/jump resolved in ID
//   ICACHE_ren/_addr         read request and word address (pc[31:2])
//   ICACHE_stall/_rdata      cache not-ready flag and returned instruction
//   if_id_instr/_pc4/_valid  IF/ID register contents (valid = 0 is a bubble)
//   fetch_stall              high while a miss is outstanding (informational)
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0]        RESET_PC = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP      = NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCWrite,
    input  logic               if_id_Write,
    input  logic               global_stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               ICACHE_ren,
    output logic [29:0]        ICACHE_addr,
    input  logic               ICACHE_stall,
    input  logic [INSTR_W-1:0] ICACHE_rdata,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic               fetch_stall
);

    fetch_state_t       state_d, state_q;
    logic [31:0]        pc_d, pc_q;
    logic               squash_d, squash_q;
    logic [31:0]        squash_pc_d, squash_pc_q;
    logic [INSTR_W-1:0] hold_d, hold_q;

    logic               redir_s;
    logic [31:0]        target_s;
    logic [31:0]        pc_plus4_s;
    logic               ifid_flush_s;
    logic               ifid_load_s;
    logic [INSTR_W-1:0] ifid_instr_s;

    // A redirect only counts when the PC is allowed to move; ID re-asserts it otherwise.
    assign redir_s    = redirect_valid & PCWrite;
    assign target_s   = align_word(redirect_pc);
    assign pc_plus4_s = pc_q + 32'd4;

    // The only word that enters IF/ID from HELD is the buffered one.
    assign ifid_instr_s = (state_q == HELD) ? hold_q : ICACHE_rdata;

    // Next-state, PC and IF/ID control.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        squash_d     = squash_q;
        squash_pc_d  = squash_pc_q;
        hold_d       = hold_q;
        ifid_flush_s = 1'b0;
        ifid_load_s  = 1'b0;
        if (global_stall) begin
            state_d = state_q;
        end else begin
            case (state_q)
                RUN, MISS: begin
                    if (ICACHE_stall) begin
                        // Miss (new or continuing): PC, and thus the address, stays put.
                        state_d      = MISS;
                        ifid_flush_s = if_id_Write;
                        if (redir_s) begin
                            squash_d    = 1'b1;
                            squash_pc_d = target_s;
                        end else begin
                            squash_d = squash_q;
                        end
                    end else begin
                        state_d = RUN;
                        if (redir_s) begin
                            // Wrong-path word: drop it, go to the (newest) target.
                            pc_d         = target_s;
                            ifid_flush_s = 1'b1;
                            squash_d     = 1'b0;
                        end else if (squash_q) begin
                            pc_d         = squash_pc_q;
                            squash_d     = 1'b0;
                            ifid_flush_s = if_id_Write;
                        end else if (PCWrite && if_id_Write) begin
                            pc_d        = pc_plus4_s;
                            ifid_load_s = 1'b1;
                        end else if (!if_id_Write) begin
                            // ID cannot take the word: park it so it is not re-fetched.
                            hold_d  = ICACHE_rdata;
                            state_d = HELD;
                        end else begin
                            // PC frozen but IF/ID open: re-fetch the same PC next cycle.
                            ifid_flush_s = 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (redir_s) begin
                        pc_d         = target_s;
                        ifid_flush_s = 1'b1;
                        state_d      = RUN;
                    end else if (if_id_Write) begin
                        pc_d        = pc_plus4_s;
                        ifid_load_s = 1'b1;
                        state_d     = RUN;
                    end else begin
                        state_d = HELD;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State, PC, pending redirect and hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            squash_q    <= 1'b0;
            squash_pc_q <= 32'h0000_0000;
            hold_q      <= NOP;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            squash_q    <= squash_d;
            squash_pc_q <= squash_pc_d;
            hold_q      <= hold_d;
        end
    end

    if_id_reg #(
        .NOP (NOP)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .flush   (ifid_flush_s),
        .en      (ifid_load_s),
        .d_instr (ifid_instr_s),
        .d_pc4   (pc_plus4_s),
        .d_valid (1'b1),
        .q_instr (if_id_instr),
        .q_pc4   (if_id_pc4),
        .q_valid (if_id_valid)
    );

    // No request while a word is parked, and none during reset.
    assign ICACHE_ren  = ~rst & (state_q != HELD);
    assign ICACHE_addr = pc_q[31:2];
    assign fetch_stall = (state_q == MISS);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, PCWrite, if_id_Write, global_stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic        ICACHE_stall;
    logic [31:0] ICACHE_rdata;
    logic [31:0] if_id_instr, if_id_pc4;
    logic        if_id_valid, fetch_stall;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOPW = 32'h0000_0000;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .PCWrite        (PCWrite),
        .if_id_Write    (if_id_Write),
        .global_stall   (global_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ICACHE_ren     (ICACHE_ren),
        .ICACHE_addr    (ICACHE_addr),
        .ICACHE_stall   (ICACHE_stall),
        .ICACHE_rdata   (ICACHE_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4),
        .if_id_valid    (if_id_valid),
        .fetch_stall    (fetch_stall)
    );

    typedef struct {
        logic        rst, gs, pw, iw, rv;
        logic [31:0] rpc;
        logic        st;
        logic [31:0] rd;
        logic        e_ren;
        logic [29:0] e_addr;
        logic [31:0] e_instr, e_pc4;
        logic        e_valid, e_fs;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic r, g, pw, iw, rv, input logic [31:0] rpc,
                                input logic st, input logic [31:0] rd,
                                input logic e_ren, input logic [29:0] e_addr,
                                input logic [31:0] e_instr, e_pc4,
                                input logic e_valid, e_fs);
        vec_t v;
        v.rst = r; v.gs = g; v.pw = pw; v.iw = iw; v.rv = rv; v.rpc = rpc;
        v.st = st; v.rd = rd; v.e_ren = e_ren; v.e_addr = e_addr;
        v.e_instr = e_instr; v.e_pc4 = e_pc4; v.e_valid = e_valid; v.e_fs = e_fs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_ren, input logic [29:0] e_addr,
                           input logic [31:0] e_instr, e_pc4, input logic e_valid, e_fs);
        chk({tag, "_ren"},   {31'd0, ICACHE_ren},  {31'd0, e_ren});
        chk({tag, "_addr"},  {2'b00, ICACHE_addr}, {2'b00, e_addr});
        chk({tag, "_instr"}, if_id_instr,          e_instr);
        chk({tag, "_pc4"},   if_id_pc4,            e_pc4);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
        chk({tag, "_fstall"},{31'd0, fetch_stall}, {31'd0, e_fs});
    endtask

    task automatic drive(input logic r, g, pw, iw, rv, input logic [31:0] rpc,
                         input logic st, input logic [31:0] rd);
        rst = r; global_stall = g; PCWrite = pw; if_id_Write = iw;
        redirect_valid = rv; redirect_pc = rpc; ICACHE_stall = st; ICACHE_rdata = rd;
    endtask

    // one clock with given inputs, then sample 1 time unit after the edge
    task automatic cyc(input logic r, g, pw, iw, rv, input logic [31:0] rpc,
                       input logic st, input logic [31:0] rd);
        drive(r, g, pw, iw, rv, rpc, st, rd);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem(input logic [29:0] a);
        return {a[14:0], a[29:13]} ^ 32'hA5C3_0F1E;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_sqt, m_hbuf, m_instr, m_pc4;
    logic        m_miss, m_held, m_sq, m_valid;

    task automatic m_bubble();
        m_instr = NOPW; m_pc4 = 32'd0; m_valid = 1'b0;
    endtask

    task automatic model_step(input logic r, g, pw, iw, rv, input logic [31:0] rpc,
                              input logic st, input logic [31:0] rd);
        logic        redir;
        logic [31:0] tgt;
        redir = rv & pw;
        tgt   = {rpc[31:2], 2'b00};
        if (r) begin
            m_pc = 32'd0; m_miss = 1'b0; m_held = 1'b0; m_sq = 1'b0; m_sqt = 32'd0;
            m_bubble();
        end else if (!g) begin
            if (m_held) begin
                if (redir) begin
                    m_bubble(); m_pc = tgt; m_held = 1'b0;
                end else if (iw) begin
                    m_instr = m_hbuf; m_pc = m_pc + 32'd4; m_pc4 = m_pc; m_valid = 1'b1;
                    m_held = 1'b0;
                end
            end else if (st) begin
                m_miss = 1'b1;
                if (iw) m_bubble();
                if (redir) begin m_sq = 1'b1; m_sqt = tgt; end
            end else begin
                m_miss = 1'b0;
                if (redir) begin
                    m_pc = tgt; m_bubble(); m_sq = 1'b0;
                end else if (m_sq) begin
                    m_pc = m_sqt; m_sq = 1'b0;
                    if (iw) m_bubble();
                end else if (pw && iw) begin
                    m_instr = rd; m_pc = m_pc + 32'd4; m_pc4 = m_pc; m_valid = 1'b1;
                end else if (!iw) begin
                    m_held = 1'b1; m_hbuf = rd;
                end else begin
                    m_bubble();
                end
            end
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);

        // ---- table: reset, hit streaming, 3-cycle miss at 0x10, redirect during miss at 0x20
        tbl[0]  = mk(1,0,1,1,0,32'd0,  0,32'd0,        0,30'd0,  NOPW,        32'd0,   0,0);
        tbl[1]  = mk(0,0,1,1,0,32'd0,  0,32'h20080001, 1,30'd1,  32'h20080001,32'd4,   1,0);
        tbl[2]  = mk(0,0,1,1,0,32'd0,  0,32'h20080002, 1,30'd2,  32'h20080002,32'd8,   1,0);
        tbl[3]  = mk(0,0,1,1,0,32'd0,  0,32'h20080003, 1,30'd3,  32'h20080003,32'hC,   1,0);
        tbl[4]  = mk(0,0,1,1,0,32'd0,  0,32'h20080004, 1,30'd4,  32'h20080004,32'h10,  1,0);
        tbl[5]  = mk(0,0,1,1,0,32'd0,  1,32'hBAD0BAD0, 1,30'd4,  NOPW,        32'd0,   0,1);
        tbl[6]  = mk(0,0,1,1,0,32'd0,  1,32'hBAD0BAD0, 1,30'd4,  NOPW,        32'd0,   0,1);
        tbl[7]  = mk(0,0,1,1,0,32'd0,  1,32'hBAD0BAD0, 1,30'd4,  NOPW,        32'd0,   0,1);
        tbl[8]  = mk(0,0,1,1,0,32'd0,  0,32'h20080005, 1,30'd5,  32'h20080005,32'h14,  1,0);
        tbl[9]  = mk(0,0,1,1,0,32'd0,  0,32'h20080006, 1,30'd6,  32'h20080006,32'h18,  1,0);
        tbl[10] = mk(0,0,1,1,0,32'd0,  0,32'h20080007, 1,30'd7,  32'h20080007,32'h1C,  1,0);
        tbl[11] = mk(0,0,1,1,0,32'd0,  0,32'h20080008, 1,30'd8,  32'h20080008,32'h20,  1,0);
        tbl[12] = mk(0,0,1,1,0,32'd0,  1,32'hBAD0BAD0, 1,30'd8,  NOPW,        32'd0,   0,1);
        tbl[13] = mk(0,0,1,1,1,32'h100,1,32'hBAD0BAD0, 1,30'd8,  NOPW,        32'd0,   0,1);
        tbl[14] = mk(0,0,1,1,0,32'd0,  0,32'h20080009, 1,30'h40, NOPW,        32'd0,   0,0);
        tbl[15] = mk(0,0,1,1,0,32'd0,  0,32'hDEAD0040, 1,30'h41, 32'hDEAD0040,32'h104, 1,0);

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].rst, tbl[i].gs, tbl[i].pw, tbl[i].iw, tbl[i].rv, tbl[i].rpc,
                tbl[i].st, tbl[i].rd);
            chk_all($sformatf("vec%0d", i), tbl[i].e_ren, tbl[i].e_addr, tbl[i].e_instr,
                    tbl[i].e_pc4, tbl[i].e_valid, tbl[i].e_fs);
        end

        // ---- hit with if_id_Write = 0 for two cycles
        cyc(1,0,1,1,0,32'd0,0,32'd0);
        cyc(0,0,1,1,0,32'd0,0,32'h11111111);
        chk_all("held_pre", 1, 30'd1, 32'h11111111, 32'd4, 1, 0);
        cyc(0,0,0,0,0,32'd0,0,32'h22222222);
        chk_all("held_c1", 0, 30'd1, 32'h11111111, 32'd4, 1, 0);
        cyc(0,0,0,0,0,32'd0,0,32'h99999999);
        chk_all("held_c2", 0, 30'd1, 32'h11111111, 32'd4, 1, 0);
        cyc(0,0,1,1,0,32'd0,0,32'h99999999);
        chk_all("held_rel", 1, 30'd2, 32'h22222222, 32'd8, 1, 0);

        // ---- redirect while PCWrite = 0 is ignored, then honoured (low bits dropped)
        cyc(0,0,0,0,1,32'h303,0,32'h33333333);
        chk_all("redir_ign", 0, 30'd2, 32'h22222222, 32'd8, 1, 0);
        cyc(0,0,1,1,1,32'h303,0,32'h77777777);
        chk_all("redir_ok", 1, 30'hC0, NOPW, 32'd0, 0, 0);

        // ---- PC wrap: redirect to 0xFFFFFFFC then hit
        cyc(0,0,1,1,1,32'hFFFF_FFFC,0,32'h12345678);
        chk_all("wrap_tgt", 1, 30'h3FFF_FFFF, NOPW, 32'd0, 0, 0);
        cyc(0,0,1,1,0,32'd0,0,32'h66666666);
        chk_all("wrap_hit", 1, 30'd0, 32'h66666666, 32'd0, 1, 0);

        // ---- global_stall over a squashed miss completion, then reset mid-MISS
        cyc(1,0,1,1,0,32'd0,0,32'd0);
        cyc(0,0,1,1,0,32'd0,0,32'h44444444);
        chk_all("gs_hit", 1, 30'd1, 32'h44444444, 32'd4, 1, 0);
        cyc(0,0,1,1,0,32'd0,1,32'hBAD0BAD0);
        chk_all("gs_miss", 1, 30'd1, NOPW, 32'd0, 0, 1);
        cyc(0,0,1,1,1,32'h200,1,32'hBAD0BAD0);
        chk_all("gs_sq", 1, 30'd1, NOPW, 32'd0, 0, 1);
        cyc(0,1,1,1,0,32'd0,0,32'h88888888);
        chk_all("gs_frz1", 1, 30'd1, NOPW, 32'd0, 0, 1);
        cyc(0,1,1,1,1,32'h400,0,32'h88888888);
        chk_all("gs_frz2", 1, 30'd1, NOPW, 32'd0, 0, 1);
        cyc(1,0,1,1,0,32'd0,1,32'hBAD0BAD0);
        chk_all("gs_rst", 0, 30'd0, NOPW, 32'd0, 0, 0);
        cyc(0,0,1,1,0,32'd0,0,32'h55555555);
        chk_all("gs_after", 1, 30'd1, 32'h55555555, 32'd4, 1, 0);

        // ---- randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            logic r, g, pw, iw, rv, st;
            logic [31:0] rpc, rd;
            int t;
            r  = (i == 0) || ($urandom_range(0, 249) == 0);
            g  = ($urandom_range(0, 99) < 10);
            t  = $urandom_range(0, 99);
            if (t < 75)      begin pw = 1'b1; iw = 1'b1; end
            else if (t < 93) begin pw = 1'b0; iw = 1'b0; end
            else             begin pw = 1'($urandom_range(0, 1)); iw = 1'($urandom_range(0, 1)); end
            rv  = ($urandom_range(0, 99) < 12);
            rpc = $urandom;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | {28'd0, 4'($urandom_range(0, 15))};
            st  = m_held ? 1'b0 : ($urandom_range(0, 9) < 3);
            rd  = mem(m_pc[31:2]);
            drive(r, g, pw, iw, rv, rpc, st, rd);
            @(posedge clk);
            model_step(r, g, pw, iw, rv, rpc, st, rd);
            #1;
            chk_all($sformatf("rnd%0d", i), ~r & ~m_held, m_pc[31:2], m_instr, m_pc4,
                    m_valid, m_miss);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
